// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM address and
// presents each fetched word with its PC to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 10'b0010000010
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_en,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_read_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_instr_valid;
    logic [DATA_WIDTH-1:0] r_instr_data;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [15:0]           r_fetch_count;

    logic                  w_load;
    logic                  w_flush;
    logic                  w_is_halt;
    logic                  w_halt_accept;

    assign w_is_halt = (rom_read_data == HALT_WORD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_flush       = 1'b0;
        w_halt_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_en) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                end else if (!r_instr_valid || instr_ready) begin
                    w_load = 1'b1;
                    if (w_is_halt) begin
                        w_state_next = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                w_halt_accept = r_instr_valid && instr_ready;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Stall (valid && !ready) falls through every branch, so all registers hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr_data  <= '0;
            r_instr_pc    <= '0;
            r_fetch_count <= '0;
        end else if (w_flush) begin
            r_pc          <= redirect_addr;
            r_instr_valid <= 1'b0;
        end else if (w_load) begin
            r_instr_data  <= rom_read_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            if (!w_is_halt) begin
                r_pc <= r_pc + 1'b1;
            end
            if (r_fetch_count != 16'hFFFF) begin
                r_fetch_count <= r_fetch_count + 16'd1;
            end
        end else if (w_halt_accept) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign rom_address = r_pc;
    assign instr_valid = r_instr_valid;
    assign instr_data  = r_instr_data;
    assign instr_pc    = r_instr_pc;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural fetch model compared every cycle,
// directed scenarios with literal expectations, then randomized episodes.
module tb_fetch_unit;

    localparam int             AW   = 10;
    localparam int             DW   = 10;
    localparam logic [DW-1:0]  HALT = 10'b0010000010;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic          run_en         = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr  = '0;
    logic          instr_ready    = 1'b0;
    logic [AW-1:0] rom_address;
    logic [DW-1:0] rom_read_data;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [DW-1:0] rom [1024];
    assign rom_read_data = rom[rom_address];

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_en         (run_en),
        .rom_address    (rom_address),
        .rom_read_data  (rom_read_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 = waiting for start, 1 = fetching, 2 = stopped on halt.
    int            m_phase = 0;
    logic [AW-1:0] m_pc    = '0;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [AW-1:0] m_ipc   = '0;
    logic [15:0]   m_cnt   = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [DW-1:0] word;
        if (!rst_n) begin
            m_phase = 0;
            m_pc    = '0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ipc   = '0;
            m_cnt   = '0;
        end else if (m_phase == 0) begin
            if (run_en) m_phase = 1;
        end else if (m_phase == 1) begin
            if (redirect_valid) begin
                m_pc    = redirect_addr;
                m_valid = 1'b0;
            end else if (!m_valid || instr_ready) begin
                word    = rom[m_pc];
                m_data  = word;
                m_ipc   = m_pc;
                m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (word == HALT) m_phase = 2;
                else              m_pc = AW'((int'(m_pc) + 1) % 1024);
            end
        end else begin
            if (m_valid && instr_ready) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid",   instr_valid, m_valid);
            check("addr",    rom_address, m_pc);
            check("halted",  halted,      m_phase == 2);
            check("count",   fetch_count, m_cnt);
            check("data",    instr_data,  m_data);
            check("ipc",     instr_pc,    m_ipc);
        end
    end

    task automatic fill_rom(input int halt_odds);
        logic [DW-1:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = DW'($urandom);
            if (halt_odds == 0) begin
                while (w == HALT) w = DW'($urandom);
            end else if ($urandom_range(0, halt_odds - 1) == 0) begin
                w = HALT;
            end
            rom[i] = w;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        run_en         = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic start();
        run_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_rom(0);
        rom[17] = HALT;

        // T1: straight-line fetch from reset
        do_reset();
        cmp_en = 1'b1;
        check("T1 reset valid", instr_valid, 0);
        check("T1 reset addr",  rom_address, 0);
        check("T1 reset count", fetch_count, 0);
        start();
        check("T1 first run cycle empty", instr_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("T1 instr_pc", instr_pc, k);
            check("T1 instr_data", instr_data, rom[k]);
        end
        check("T1 count", fetch_count, 4);
        check("T1 rom_address", rom_address, 4);

        // T2: decode stall holds everything
        do_reset();
        start();
        repeat (3) @(negedge clk);
        check("T2 pre-stall pc", instr_pc, 2);
        instr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("T2 stall pc", instr_pc, 2);
            check("T2 stall addr", rom_address, 3);
            check("T2 stall count", fetch_count, 3);
            check("T2 stall valid", instr_valid, 1);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("T2 resume pc", instr_pc, 3);

        // T3: redirect flushes and costs one bubble
        for (int n = 0; n < 40 && instr_pc != 15; n++) @(negedge clk);
        check("T3 reached pc 15", instr_pc, 15);
        redirect_valid = 1'b1;
        redirect_addr  = 10'd10;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("T3 bubble valid", instr_valid, 0);
        check("T3 redirected addr", rom_address, 10);
        @(negedge clk);
        check("T3 target pc", instr_pc, 10);
        check("T3 target valid", instr_valid, 1);

        // T4: halt word freezes the PC and ignores redirects
        for (int n = 0; n < 40 && !halted; n++) @(negedge clk);
        check("T4 halted", halted, 1);
        check("T4 halt data", instr_data, 10'b0010000010);
        check("T4 halt pc", instr_pc, 17);
        check("T4 halt addr", rom_address, 17);
        check("T4 halt valid", instr_valid, 1);
        check("T4 halt count", fetch_count, 24);
        redirect_valid = 1'b1;
        redirect_addr  = 10'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("T4 accepted valid", instr_valid, 0);
        repeat (3) @(negedge clk);
        check("T4 frozen addr", rom_address, 17);
        check("T4 still halted", halted, 1);

        // T5: PC wraps from 1023 to 0
        do_reset();
        start();
        redirect_valid = 1'b1;
        redirect_addr  = 10'd1023;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("T5 addr 1023", rom_address, 1023);
        @(negedge clk);
        check("T5 pc 1023", instr_pc, 1023);
        @(negedge clk);
        check("T5 pc wrap", instr_pc, 0);
        check("T5 addr after wrap", rom_address, 1);

        // T6: asynchronous reset in the middle of a stall
        do_reset();
        start();
        repeat (3) @(negedge clk);
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("T6 stalled valid", instr_valid, 1);
        #2;
        rst_n  = 1'b0;
        run_en = 1'b0;
        #1;
        check("T6 async valid", instr_valid, 0);
        check("T6 async addr", rom_address, 0);
        check("T6 async count", fetch_count, 0);
        check("T6 async halted", halted, 0);
        @(negedge clk);
        #2;
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("T6 idle valid", instr_valid, 0);
            check("T6 idle addr", rom_address, 0);
        end

        // Randomized episodes against the model
        for (int ep = 0; ep < 30; ep++) begin
            fill_rom(48);
            do_reset();
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                run_en      = ($urandom_range(0, 3) == 0);
                instr_ready = ($urandom_range(0, 3) != 0);
                if (!redirect_valid && $urandom_range(0, 9) == 0) begin
                    redirect_valid = 1'b1;
                    redirect_addr  = ($urandom_range(0, 3) == 0) ? AW'(1020 + $urandom_range(0, 3))
                                                                 : AW'($urandom);
                end else begin
                    redirect_valid = 1'b0;
                end
                if (c == 150 && (ep % 3) == 0) begin
                    #3;
                    rst_n = 1'b0;
                    @(negedge clk);
                    #2;
                    rst_n = 1'b1;
                end
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
